// File: rtl/iobus_pkg.sv
// Shared IOBUS port map and rectangle-fill state encoding.
// Also holds the small length-clipping helper used by the fill walker.
package iobus_pkg;

   localparam logic [31:0] IOBUS_LEDS_ADDR   = 32'h1100C000;
   localparam logic [31:0] IOBUS_SSEG_ADDR   = 32'h1100C004;
   localparam logic [31:0] IOBUS_VGA_WR_ADDR = 32'h1100C010;

   typedef enum logic [1:0] {
      FILL_IDLE  = 2'd0,
      FILL_SETUP = 2'd1,
      FILL_WRITE = 2'd2,
      FILL_DONE  = 2'd3
   } fill_state_t;

   // Clip a requested span to the room left before the screen edge.
   function automatic logic [7:0] clip_len(input logic [7:0] len, input logic [16:0] room);
      logic [7:0] res;
      if ({9'd0, len} <= room) begin
         res = len;
      end else begin
         res = room[7:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/rect_walker.sv
// Row-major pixel walker: clips the rectangle against the screen and steps
// the pixel index once per granted write.
module rect_walker
   import iobus_pkg::*;
#(
   parameter int COLS = 160,
   parameter int ROWS = 120
) (
   input  logic        clk,
   input  logic        RST_N,
   input  logic        load,
   input  logic        step,
   input  logic [7:0]  x0,
   input  logic [7:0]  y0,
   input  logic [7:0]  width,
   input  logic [7:0]  height,
   output logic [15:0] pix,
   output logic        last
);

   localparam logic [16:0] COLS_W = 17'(COLS);
   localparam logic [16:0] ROWS_W = 17'(ROWS);

   logic [16:0] col_room_s;
   logic [16:0] row_room_s;
   logic [16:0] base_s;
   logic [16:0] next_base_s;
   logic [16:0] pix_r;
   logic [16:0] row_base_r;
   logic [7:0]  col_r;
   logic [7:0]  row_r;
   logic [7:0]  w_eff_r;
   logic [7:0]  h_eff_r;

   // Clip room, rectangle origin and next-row base arithmetic.
   always_comb begin
      col_room_s  = COLS_W - {9'd0, x0};
      row_room_s  = ROWS_W - {9'd0, y0};
      base_s      = ({9'd0, y0} * COLS_W) + {9'd0, x0};
      next_base_s = row_base_r + COLS_W;
      pix         = pix_r[15:0];
      last        = (col_r == (w_eff_r - 8'd1)) && (row_r == (h_eff_r - 8'd1));
   end

   // Walker registers: load on setup, advance only on a granted write.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         pix_r      <= 17'd0;
         row_base_r <= 17'd0;
         col_r      <= 8'd0;
         row_r      <= 8'd0;
         w_eff_r    <= 8'd0;
         h_eff_r    <= 8'd0;
      end else if (load) begin
         w_eff_r    <= clip_len(width, col_room_s);
         h_eff_r    <= clip_len(height, row_room_s);
         row_base_r <= base_s;
         pix_r      <= base_s;
         col_r      <= 8'd0;
         row_r      <= 8'd0;
      end else if (step) begin
         if (col_r == (w_eff_r - 8'd1)) begin
            row_base_r <= next_base_s;
            pix_r      <= next_base_s;
            col_r      <= 8'd0;
            row_r      <= row_r + 8'd1;
         end else begin
            pix_r      <= pix_r + 17'd1;
            col_r      <= col_r + 8'd1;
         end
      end
   end

endmodule

// File: rtl/iobus_rect_fill.sv
// Rectangle fill engine: turns one command into a stream of packed
// colour/pixel writes on the IOBUS, clipped to the VRAM bounds.
module iobus_rect_fill
   import iobus_pkg::*;
#(
   parameter int          COLS    = 160,
   parameter int          ROWS    = 120,
   parameter logic [31:0] WR_ADDR = IOBUS_VGA_WR_ADDR
) (
   input  logic        clk,
   input  logic        RST_N,
   input  logic        start,
   input  logic [7:0]  x0,
   input  logic [7:0]  y0,
   input  logic [7:0]  width,
   input  logic [7:0]  height,
   input  logic [11:0] color,
   input  logic        abort,
   input  logic        bus_gnt,
   output logic        bus_req,
   output logic [31:0] iobus_addr,
   output logic [31:0] iobus_out,
   output logic        iobus_wr,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [16:0] COLS_W = 17'(COLS);
   localparam logic [16:0] ROWS_W = 17'(ROWS);

   fill_state_t state_r;
   logic [7:0]  x0_r;
   logic [7:0]  y0_r;
   logic [7:0]  width_r;
   logic [7:0]  height_r;
   logic [11:0] color_r;
   logic        err_r;
   logic        busy_r;
   logic        done_r;
   logic        bus_req_r;
   logic [31:0] addr_r;
   logic        invalid_s;
   logic        load_s;
   logic [15:0] pix_s;
   logic        last_s;

   // Command qualification and bus-side decode.
   always_comb begin
      invalid_s = (width_r == 8'd0) || (height_r == 8'd0) ||
                  ({9'd0, x0_r} >= COLS_W) || ({9'd0, y0_r} >= ROWS_W);
      load_s    = (state_r == FILL_SETUP);
      iobus_wr  = bus_req_r & bus_gnt;
      if (bus_req_r) begin
         iobus_out = {4'b0000, color_r, pix_s};
      end else begin
         iobus_out = 32'd0;
      end
   end

   assign bus_req    = bus_req_r;
   assign iobus_addr = addr_r;
   assign busy       = busy_r;
   assign done       = done_r;
   assign err        = err_r;

   rect_walker #(
      .COLS (COLS),
      .ROWS (ROWS)
   ) u_walker (
      .clk    (clk),
      .RST_N  (RST_N),
      .load   (load_s),
      .step   (iobus_wr),
      .x0     (x0_r),
      .y0     (y0_r),
      .width  (width_r),
      .height (height_r),
      .pix    (pix_s),
      .last   (last_s)
   );

   // Fill FSM; status and bus outputs are registered alongside the state.
   always_ff @(posedge clk) begin
      if (!RST_N) begin
         state_r   <= FILL_IDLE;
         x0_r      <= 8'd0;
         y0_r      <= 8'd0;
         width_r   <= 8'd0;
         height_r  <= 8'd0;
         color_r   <= 12'd0;
         err_r     <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         bus_req_r <= 1'b0;
         addr_r    <= 32'd0;
      end else begin
         case (state_r)
            FILL_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  x0_r     <= x0;
                  y0_r     <= y0;
                  width_r  <= width;
                  height_r <= height;
                  color_r  <= color;
                  err_r    <= 1'b0;
                  busy_r   <= 1'b1;
                  state_r  <= FILL_SETUP;
               end
            end
            FILL_SETUP: begin
               if (invalid_s) begin
                  err_r   <= 1'b1;
                  done_r  <= 1'b1;
                  state_r <= FILL_DONE;
               end else begin
                  bus_req_r <= 1'b1;
                  addr_r    <= WR_ADDR;
                  state_r   <= FILL_WRITE;
               end
            end
            FILL_WRITE: begin
               // A write granted alongside abort still lands this cycle.
               if (abort || (bus_gnt && last_s)) begin
                  bus_req_r <= 1'b0;
                  addr_r    <= 32'd0;
                  done_r    <= 1'b1;
                  state_r   <= FILL_DONE;
               end
            end
            FILL_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= FILL_IDLE;
            end
            default: begin
               done_r    <= 1'b0;
               busy_r    <= 1'b0;
               bus_req_r <= 1'b0;
               addr_r    <= 32'd0;
               state_r   <= FILL_IDLE;
            end
         endcase
      end
   end

endmodule
